pulse_train_gen: RTL

- Synchronous stimulus source that drives the input of the NOR-based delay chain under test with programmable pulse trains.
- Pulse width, gap and count are configurable per run, so the chain's response to narrow pulses and glitch trains can be measured.
- Sits directly upstream of the chain; `pulse_out` connects to the chain's `myin` with no logic in between.
- Output is a flop, so it is glitch-free.

---
 rtl/pulse_train_pkg.sv | 19 +
 rtl/pulse_lfsr.sv | 27 ++
 rtl/pulse_train_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the pulse train generator that drives the
// NOR delay chain under test.
package pulse_train_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_W_DEF  = 8;
  localparam int LFSR_W_DEF = 8;

  // Galois feedback taps for an 8-bit maximal-length LFSR.
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_lfsr.sv
// Right-shifting Galois LFSR used to jitter the gap length; seeded with 1 on
// reset so the sequence never reaches the all-zero lockup state.
module pulse_lfsr
  import pulse_train_pkg::*;
#(
  parameter int         W    = LFSR_W_DEF,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS_8)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_adv,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= W'(1);
    end else if (i_adv) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train source feeding the delay chain input (myin).
// Define PULSE_TRAIN_JITTER_EN to add an LFSR-jittered gap length.
//
// Config handshake: a request is accepted on any clk edge where
// cfg_valid && cfg_ready; cfg_ready is high only in IDLE, and cfg_* are
// ignored at every other time.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NUM_W  = NUM_W_DEF,
  parameter int LFSR_W = LFSR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [NUM_W-1:0] cfg_count,
  input  logic             cfg_idle_level,
`ifdef PULSE_TRAIN_JITTER_EN
  input  logic [CNT_W-1:0] cfg_jitter_mask,
`endif
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx,
  output state_t           dbg_state
);

  state_t           r_state;
  logic             r_pulse;
  logic             r_idle;
  logic             r_busy;
  logic             r_done;
  logic [NUM_W-1:0] r_idx;
  logic [NUM_W-1:0] r_count;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_m1;
  logic [CNT_W-1:0] r_low_len;

  logic [CNT_W-1:0] w_high_m1;
  logic [CNT_W-1:0] w_low_len;
  logic [CNT_W-1:0] w_gap_len;
  logic [CNT_W-1:0] w_gap_m1;
  logic             w_last;
  logic             w_phase_end;

  // Zero-length phases are widened to one cycle so the counters never wrap.
  assign w_high_m1   = (cfg_high == '0) ? '0 : cfg_high - CNT_W'(1);
  assign w_low_len   = (cfg_low == '0) ? CNT_W'(1) : cfg_low;
  assign w_last      = (r_idx == r_count - NUM_W'(1));
  assign w_phase_end = (r_cnt == '0);

`ifdef PULSE_TRAIN_JITTER_EN
  logic [CNT_W-1:0]  r_mask;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_lfsr_adv;
  logic [CNT_W:0]    w_gap_sum;

  // Advance once per LOW entry; the value current at that edge sets the gap.
  assign w_lfsr_adv = (r_state == HIGH) && w_phase_end && !w_last;
  assign w_gap_sum  = {1'b0, r_low_len} + {1'b0, CNT_W'(w_lfsr) & r_mask};
  assign w_gap_len  = w_gap_sum[CNT_W] ? '1 : w_gap_sum[CNT_W-1:0];

  pulse_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_W'(LFSR_TAPS_8))
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_adv   (w_lfsr_adv),
    .o_value (w_lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (r_state == IDLE && cfg_valid) begin
      r_mask <= cfg_jitter_mask;
    end
  end
`else
  assign w_gap_len = r_low_len;
`endif

  assign w_gap_m1 = w_gap_len - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pulse   <= 1'b0;
      r_idle    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
      r_count   <= '0;
      r_cnt     <= '0;
      r_high_m1 <= '0;
      r_low_len <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_pulse <= r_idle;
          if (cfg_valid) begin
            r_idle    <= cfg_idle_level;
            r_count   <= cfg_count;
            r_high_m1 <= w_high_m1;
            r_low_len <= w_low_len;
            r_idx     <= '0;
            if (cfg_count == '0) begin
              r_state <= DONE;
              r_pulse <= cfg_idle_level;
              r_done  <= 1'b1;
            end else begin
              r_state <= HIGH;
              r_pulse <= ~cfg_idle_level;
              r_busy  <= 1'b1;
              r_cnt   <= w_high_m1;
            end
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            r_pulse <= r_idle;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOW;
              r_cnt   <= w_gap_m1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (w_phase_end) begin
            r_state <= HIGH;
            r_pulse <= ~r_idle;
            r_idx   <= r_idx + NUM_W'(1);
            r_cnt   <= r_high_m1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_ready = (r_state == IDLE);
  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_idx = r_idx;
  assign dbg_state = r_state;

endmodule
